// File: rtl/sram_access_seq.sv
// Single-byte SRAM read/write sequencer with a serially loaded address register.
// Optional build macro SRAM_ADDR_AUTOINC_EN: post-increment the address after every completed access.
module sram_access_seq #(
    parameter int AWIDTH      = 21,
    parameter int DWIDTH      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_si,
    input  logic              addr_shift,
    input  logic              req,
    input  logic              wr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic [AWIDTH-1:0] addr,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [DWIDTH-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DWIDTH-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              den_q, den_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
            dout_q  <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            den_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            den_q   <= den_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // A request takes priority; a coincident shift bit is dropped.
                if (req) begin
                    wr_d    = wr;
                    state_d = SETUP;
                end else if (addr_shift) begin
                    addr_d = {addr_q[AWIDTH-2:0], addr_si};
                end
            end
            SETUP: begin
                cnt_d   = CW'(WAIT_CYCLES - 1);
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    if (!wr_q) rdata_d = sram_din;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
`ifdef SRAM_ADDR_AUTOINC_EN
                addr_d  = addr_q + AWIDTH'(1);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so each one lines up with its state cycle.
    always_comb begin
        ce_n_d = (state_d == IDLE);
        oe_n_d = !((state_d == STROBE) && !wr_d);
        we_n_d = !((state_d == STROBE) && wr_d);
        den_d  = (state_d != IDLE) && wr_d;
        ack_d  = (state_d == HOLD);
        busy_d = (state_d != IDLE);
        dout_d = dout_q;
        if (state_q == IDLE && req && wr) dout_d = wdata;
    end

    assign rdata        = rdata_q;
    assign ack          = ack_q;
    assign busy         = busy_q;
    assign addr         = addr_q;
    assign sram_addr    = addr_q;
    assign sram_dout    = dout_q;
    assign sram_dout_en = den_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;

endmodule

// File: tb/tb_sram_access_seq.sv
// Randomized self-checking bench for sram_access_seq against a cycle-count access model.
module tb_sram_access_seq;

    localparam int AW = 21;
    localparam int DW = 8;
    localparam int W  = 2;

    logic          clk, rst_n, addr_si, addr_shift, req, wr;
    logic [DW-1:0] wdata, rdata, sram_dout, sram_din;
    logic [AW-1:0] addr, sram_addr;
    logic          ack, busy, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n;

    int            errs, checks;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rdata;

    sram_access_seq #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .addr_si(addr_si), .addr_shift(addr_shift),
        .req(req), .wr(wr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
        .addr(addr), .sram_addr(sram_addr), .sram_dout(sram_dout),
        .sram_dout_en(sram_dout_en), .sram_din(sram_din), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare order: {ce_n, oe_n, we_n, dout_en, ack, busy}
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, ack, busy} !== 6'b111000) begin
            errs++;
            $display("FAIL reset_ctrl: got %b exp 111000",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, ack, busy});
        end
        checks++;
        if (addr !== '0 || rdata !== '0) begin
            errs++;
            $display("FAIL reset_data: addr=%h rdata=%h exp 0/0", addr, rdata);
        end
        rst_n   = 1'b1;
        m_addr  = '0;
        m_rdata = '0;
        step();
    endtask

    task automatic test_shift(input logic [AW-1:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            addr_shift = 1'b1;
            addr_si    = val[i];
            step();
            m_addr = {m_addr[AW-2:0], val[i]};
        end
        addr_shift = 1'b0;
        checks++;
        if (addr !== m_addr || sram_addr !== m_addr) begin
            errs++;
            $display("FAIL shift_addr: addr=%h sram_addr=%h exp %h", addr, sram_addr, m_addr);
        end
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, ack, busy} !== 6'b111000) begin
            errs++;
            $display("FAIL shift_idle_ctrl: got %b exp 111000",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, ack, busy});
        end
    endtask

    // One access; the model is the cycle numbering: 1 = setup, 2..W+1 = strobe, W+2 = hold/ack.
    task automatic do_access(input logic w, input logic [DW-1:0] wd, input logic [DW-1:0] din,
                             input logic inj_req, input logic shift_with_req);
        logic       strobe;
        logic [5:0] exp_ctrl;
        logic [DW-1:0] exp_rd;
        req        = 1'b1;
        wr         = w;
        wdata      = wd;
        sram_din   = $urandom;
        addr_shift = shift_with_req;
        addr_si    = ~m_addr[AW-1];
        step();
        for (int k = 1; k <= W + 2; k++) begin
            req        = inj_req && (k == 2);
            wr         = $urandom;
            wdata      = $urandom;
            addr_shift = $urandom;
            addr_si    = $urandom;
            sram_din   = (k == W + 1) ? din : DW'($urandom);
            strobe     = (k >= 2) && (k <= W + 1);
            exp_ctrl   = {1'b0, !(strobe && !w), !(strobe && w), w, (k == W + 2), 1'b1};
            exp_rd     = (k == W + 2 && !w) ? din : m_rdata;
            checks++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, ack, busy} !== exp_ctrl) begin
                errs++;
                $display("FAIL access_ctrl cyc%0d wr=%b: got %b exp %b", k, w,
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, ack, busy}, exp_ctrl);
            end
            checks++;
            if (rdata !== exp_rd || sram_addr !== m_addr || addr !== m_addr) begin
                errs++;
                $display("FAIL access_data cyc%0d: rdata=%h exp %h addr=%h sram_addr=%h exp %h",
                         k, rdata, exp_rd, addr, sram_addr, m_addr);
            end
            if (w) begin
                checks++;
                if (sram_dout !== wd) begin
                    errs++;
                    $display("FAIL write_data cyc%0d: got %h exp %h", k, sram_dout, wd);
                end
            end
            step();
        end
        req        = 1'b0;
        addr_shift = 1'b0;
        if (!w) m_rdata = din;
`ifdef SRAM_ADDR_AUTOINC_EN
        m_addr = m_addr + 1'b1;
`endif
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, ack, busy} !== 6'b111000 ||
                addr !== m_addr || rdata !== m_rdata) begin
                errs++;
                $display("FAIL access_end +%0d: ctrl=%b exp 111000 addr=%h exp %h rdata=%h exp %h",
                         k, {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, ack, busy},
                         addr, m_addr, rdata, m_rdata);
            end
            step();
        end
    endtask

    task automatic test_autoinc();
        test_shift('1, AW);
        do_access(1'b0, 8'h00, 8'h11, 1'b0, 1'b0);
        do_access(1'b0, 8'h00, 8'h22, 1'b0, 1'b0);
        checks++;
`ifdef SRAM_ADDR_AUTOINC_EN
        if (addr !== 21'h000001) begin
            errs++;
            $display("FAIL autoinc_final: got %h exp 000001", addr);
        end
`else
        if (addr !== 21'h1FFFFF) begin
            errs++;
            $display("FAIL autoinc_final: got %h exp 1fffff", addr);
        end
`endif
    endtask

    task automatic test_reset_mid();
        req   = 1'b1;
        wr    = 1'b1;
        wdata = 8'hA5;
        step();
        req = 1'b0;
        step();
        checks++;
        if (sram_we_n !== 1'b0) begin
            errs++;
            $display("FAIL midrst_pre: we_n=%b exp 0", sram_we_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sram_ce_n, sram_we_n, sram_dout_en, busy, ack} !== 5'b11000 || addr !== '0) begin
            errs++;
            $display("FAIL midrst_async: ctrl=%b exp 11000 addr=%h exp 0",
                     {sram_ce_n, sram_we_n, sram_dout_en, busy, ack}, addr);
        end
        m_addr  = '0;
        m_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0 || sram_ce_n !== 1'b1) begin
                errs++;
                $display("FAIL midrst_hold: ack=%b ce_n=%b exp 0/1", ack, sram_ce_n);
            end
        end
        rst_n = 1'b1;
        step();
        do_access(1'b0, 8'h00, 8'h6E, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1)) test_shift(AW'($urandom), $urandom_range(1, AW));
            do_access(1'($urandom), DW'($urandom), DW'($urandom),
                      1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        errs = 0; checks = 0;
        addr_si = 0; addr_shift = 0; req = 0; wr = 0; wdata = '0; sram_din = '0;
        rst_n = 0;
        test_reset();
        test_shift(21'h1ABCDE, AW);
        do_access(1'b1, 8'h5A, 8'h00, 1'b0, 1'b0);
        do_access(1'b0, 8'h00, 8'hC3, 1'b0, 1'b0);
        do_access(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        do_access(1'b0, 8'h00, 8'h3C, 1'b1, 1'b0);
        do_access(1'b1, 8'h77, 8'h00, 1'b0, 1'b1);
        test_autoinc();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
